// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I word, opcode and fetch-entry types
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    localparam logic [6:0] op_br   = 7'b1100011;
    localparam logic [6:0] op_jalr = 7'b1100111;

    typedef struct packed {
        rv32i_word instr;
        rv32i_word pc;
    } fetch_entry_t;

    // Conditional branches and jalr resolve late; jal targets are known at fetch.
    function automatic logic is_shadowing(input rv32i_word instr);
        return (instr[6:0] == op_br) || (instr[6:0] == op_jalr);
    endfunction

endpackage

// File: rtl/fetch_buffer_shadow_tracker.sv
// rtl/fetch_buffer_shadow_tracker.sv - saturating count of unresolved branches already issued to decode
module shadow_tracker #(
    parameter int SHADOW_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic under_shadow,
    output logic at_max
);

    logic [SHADOW_W-1:0] cnt;

    assign at_max       = (cnt == {SHADOW_W{1'b1}});
    assign under_shadow = (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !dec && !at_max) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - fetch-to-decode instruction queue with branch shadow tracking; FETCH_BUF_BYPASS_EN enables empty-buffer bypass
module fetch_buffer
    import rv32i_types::*;
#(
    parameter int DEPTH    = 8,
    parameter int SHADOW_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  rv32i_word                enq_instr,
    input  rv32i_word                enq_pc,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output rv32i_word                deq_instr,
    output rv32i_word                deq_pc,
    output logic                     under_shadow,
    input  logic                     br_resolve,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [AW:0]  rd_ptr;
    logic [AW:0]  wr_ptr;
    logic         empty;
    logic         full;
    logic         at_max;
    logic         do_deq;
    logic         do_push;
    logic         do_pop;
    logic         shadow_inc;
    fetch_entry_t head;
    fetch_entry_t deq_entry;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign enq_ready = !full;
    assign count     = wr_ptr - rd_ptr;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign deq_instr = deq_entry.instr;
    assign deq_pc    = deq_entry.pc;

    // A shadowing head is held back while the tracker is saturated so it never overflows.
    always_comb begin
        deq_entry = head;
        deq_valid = !empty && !(is_shadowing(head.instr) && at_max);
`ifdef FETCH_BUF_BYPASS_EN
        if (empty && enq_valid && deq_ready && !flush && !rst) begin
            deq_entry = '{instr: enq_instr, pc: enq_pc};
            deq_valid = !(is_shadowing(enq_instr) && at_max);
        end
`endif
        do_deq  = deq_valid && deq_ready;
        do_pop  = do_deq && !empty;
        do_push = enq_valid && enq_ready && !(do_deq && empty);
    end

    assign shadow_inc = do_deq && is_shadowing(deq_entry.instr);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= '{instr: enq_instr, pc: enq_pc};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    shadow_tracker #(
        .SHADOW_W (SHADOW_W)
    ) u_shadow_tracker (
        .clk          (clk),
        .rst          (rst),
        .clr          (flush),
        .inc          (shadow_inc),
        .dec          (br_resolve),
        .under_shadow (under_shadow),
        .at_max       (at_max)
    );

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - randomized and directed checks of fetch_buffer against a queue-based reference model
module tb_fetch_buffer;

    localparam int DEPTH    = 8;
    localparam int SHADOW_W = 3;
    localparam int MAXS     = (1 << SHADOW_W) - 1;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        enq_valid;
    logic        enq_ready;
    logic [31:0] enq_instr;
    logic [31:0] enq_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;
    logic        under_shadow;
    logic        br_resolve;
    logic [3:0]  count;

    int   n_cmp = 0;
    int   n_bad = 0;
    ent_t q[$];
    int   sc;

    always #5 clk = ~clk;

    fetch_buffer #(
        .DEPTH    (DEPTH),
        .SHADOW_W (SHADOW_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .enq_valid    (enq_valid),
        .enq_ready    (enq_ready),
        .enq_instr    (enq_instr),
        .enq_pc       (enq_pc),
        .deq_valid    (deq_valid),
        .deq_ready    (deq_ready),
        .deq_instr    (deq_instr),
        .deq_pc       (deq_pc),
        .under_shadow (under_shadow),
        .br_resolve   (br_resolve),
        .count        (count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit shd(input logic [31:0] i);
        return (i[6:0] == 7'h63) || (i[6:0] == 7'h67);
    endfunction

    task automatic set_idle();
        rst        = 1'b0;
        flush      = 1'b0;
        enq_valid  = 1'b0;
        enq_instr  = '0;
        enq_pc     = '0;
        deq_ready  = 1'b0;
        br_resolve = 1'b0;
    endtask

    // Drive one cycle of inputs, check outputs against the model, then advance the model.
    task automatic cycle(input bit ev, input logic [31:0] ins, input logic [31:0] p,
                         input bit dr, input bit br, input bit fl, input bit r);
        bit          byp;
        bit          m_dv;
        bit          m_er;
        bit          deq;
        bit          enq;
        bit          inc;
        logic [31:0] m_i;
        logic [31:0] m_p;
        byp = 0;
        m_dv = 0;
        m_i = '0;
        m_p = '0;
        rst = r; flush = fl; enq_valid = ev; enq_instr = ins; enq_pc = p;
        deq_ready = dr; br_resolve = br;
        #1;
        m_er = (q.size() < DEPTH);
        if (q.size() > 0) begin
            m_i  = q[0].instr;
            m_p  = q[0].pc;
            m_dv = !(shd(m_i) && sc == MAXS);
        end
`ifdef FETCH_BUF_BYPASS_EN
        if (q.size() == 0 && ev && dr && !fl && !r) begin
            byp  = 1;
            m_i  = ins;
            m_p  = p;
            m_dv = !(shd(ins) && sc == MAXS);
        end
`endif
        check("deq_valid", deq_valid, m_dv);
        check("enq_ready", enq_ready, m_er);
        check("count", count, q.size());
        check("under_shadow", under_shadow, sc != 0);
        if (m_dv) begin
            check("deq_instr", deq_instr, m_i);
            check("deq_pc", deq_pc, m_p);
        end
        deq = m_dv && dr;
        enq = ev && m_er && !(byp && deq);
        @(posedge clk);
        if (r || fl) begin
            q.delete();
            sc = 0;
        end else begin
            inc = deq && shd(m_i);
            if (deq && !byp) void'(q.pop_front());
            if (enq) q.push_back('{instr: ins, pc: p});
            if (inc && !br && sc < MAXS) sc++;
            else if (br && !inc && sc > 0) sc--;
        end
        @(negedge clk);
        set_idle();
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        sc = 0;
        #1;
        check("rst_count", count, 0);
        check("rst_deq_valid", deq_valid, 0);
        check("rst_enq_ready", enq_ready, 1);
        check("rst_under_shadow", under_shadow, 0);
        check("rst_deq_instr", deq_instr, 0);
        check("rst_deq_pc", deq_pc, 0);
    endtask

    initial begin
        logic [31:0] ops [4];
        ops[0] = 32'h0000_0013;
        ops[1] = 32'h0000_0063;
        ops[2] = 32'h0000_0067;
        ops[3] = 32'h0000_006f;
        set_idle();
        @(negedge clk);

        // Fill, overfill, drain in order
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 32'h13, i * 4, 0, 0, 0, 0);
        check("t1_count_full", count, 8);
        check("t1_enq_ready_full", enq_ready, 0);
        cycle(1, 32'h13, 32'h20, 0, 0, 0, 0);
        check("t1_count_after_9th", count, 8);
        for (int i = 0; i < 8; i++) begin
            check("t1_drain_pc", deq_pc, i * 4);
            cycle(0, 0, 0, 1, 0, 0, 0);
        end
        check("t1_drained_valid", deq_valid, 0);

        // Streaming across pointer wrap
        do_reset();
        cycle(1, 32'h13, 32'h100, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            check("t2_stream_pc", deq_pc, 32'h100 + 4 * (i - 1));
            cycle(1, 32'h13, 32'h100 + 4 * i, 1, 0, 0, 0);
            check("t2_count", count, 1);
        end

        // Shadow set by beq, cleared by resolve
        do_reset();
        cycle(1, 32'h63, 32'h0, 0, 0, 0, 0);
        cycle(1, 32'h13, 32'h4, 0, 0, 0, 0);
        cycle(1, 32'h13, 32'h8, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        check("t3_addi_shadow", under_shadow, 1);
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        check("t3_resolved_shadow", under_shadow, 0);
        check("t3_head_pc", deq_pc, 32'h8);

        // Saturation stall and release
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 32'h63, i * 4, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 1, 0, 0, 0);
        check("t4_stall_valid", deq_valid, 0);
        check("t4_stall_count", count, 1);
        cycle(0, 0, 0, 1, 0, 0, 0);
        check("t4_still_held", count, 1);
        cycle(0, 0, 0, 0, 1, 0, 0);
        check("t4_release_valid", deq_valid, 1);
        cycle(0, 0, 0, 1, 1, 0, 0);
        check("t4_deq_resolve_shadow", under_shadow, 1);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, 0, 0);
        check("t4_all_resolved", under_shadow, 0);

        // Flush with entries and shadow state pending
        do_reset();
        cycle(1, 32'h63, 32'h0, 0, 0, 0, 0);
        cycle(1, 32'h67, 32'h4, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 32'h13, 32'h10 + i * 4, 0, 0, 0, 0);
        check("t5_pre_count", count, 5);
        check("t5_pre_shadow", under_shadow, 1);
        cycle(1, 32'h13, 32'h500, 0, 0, 1, 0);
        check("t5_flush_count", count, 0);
        check("t5_flush_valid", deq_valid, 0);
        check("t5_flush_shadow", under_shadow, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("t5_entry_absent", count, 0);

`ifdef FETCH_BUF_BYPASS_EN
        // Zero-latency bypass on an empty buffer
        do_reset();
        cycle(1, 32'h13, 32'h40, 1, 0, 0, 0);
        check("t6_bypass_count", count, 0);
`endif

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 99) < 60, ops[$urandom_range(0, 3)] | ($urandom & 32'hffff_ff80),
                  $urandom, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 2, $urandom_range(0, 999) < 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction queue between the fetch unit and the decode stage.
- Buffers {instr, pc} pairs from fetch and presents them in order to decode.
- Generates decode's under_shadow input by tracking unresolved control-flow instructions that have already left the buffer.
- Supports a pipeline flush for branch mispredicts.

Parameters:
- DEPTH, 8, number of buffer entries; must be a power of two and at least 2.
- SHADOW_W, 3, width of the unresolved-branch counter; maximum count is 2^SHADOW_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- flush  in  1  mispredict/redirect; empties the buffer and clears shadow state.
- enq_valid  in  1  fetch presents an instruction.
- enq_ready  out  1  buffer can accept this cycle.
- enq_instr  in  32  rv32i_word instruction.
- enq_pc  in  32  rv32i_word pc.
- deq_valid  out  1  head entry is available to decode.
- deq_ready  in  1  decode accepts the head.
- deq_instr  out  32  head instruction (feeds decode instr).
- deq_pc  out  32  head pc (feeds decode pc).
- under_shadow  out  1  head is younger than an unresolved branch/jalr (feeds decode under_shadow).
- br_resolve  in  1  one previously dequeued branch/jalr resolved this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage is a circular array.
- rd_ptr/wr_ptr are $clog2(DEPTH) bits plus one wrap bit.
- full is signalled when the pointers are equal and the wrap bits differ.
- empty is signalled when the pointers and the wrap bits are equal.
- Reset: pointers=0, count=0, shadow_cnt=0, storage=0, deq_valid=0, enq_ready=1, under_shadow=0, deq_instr=0, deq_pc=0.
- enq_ready = !full, registered-state only; it has no combinational path from deq_ready.
- An enqueue occurs when enq_valid && enq_ready.
- A dequeue occurs when deq_valid && deq_ready.
- deq_valid = !empty && !(head_is_shadowing && shadow_cnt==max).
- head_is_shadowing = head opcode is BRANCH (7'b1100011) or JALR (7'b1100111). JAL does not shadow.
- Latency: an enqueued entry is visible on deq_* the cycle after enqueue, with bypass disabled.
- Simultaneous enqueue and dequeue: both occur, count is unchanged, and the pointers advance modulo DEPTH with the wrap bit toggling.
- Empty with enqueue: the entry is written and deq_valid stays 0 in that cycle.
- Full: enq_ready=0. An enqueue attempt is ignored with no overwrite.
- under_shadow = (shadow_cnt != 0); it describes the current head only.
- shadow_cnt update per cycle:
  - +1 on dequeue of a shadowing instruction.
  - -1 on br_resolve.
  - Both in the same cycle: net unchanged.
  - br_resolve with shadow_cnt==0: ignored, no underflow.
  - The counter never exceeds max; dequeue is stalled by the deq_valid rule above.
- flush has priority over all other events.
  - Next cycle: pointers=0, count=0, shadow_cnt=0, deq_valid=0.
  - An enqueue or dequeue in the flush cycle has no effect.
  - br_resolve in the flush cycle is ignored.
- rst mid-operation behaves as flush and also zeroes storage.
- deq_instr/deq_pc are valid only when deq_valid=1; they hold stale storage otherwise.

Optional Feature:
- FETCH_BUF_BYPASS_EN.
- Defined: when the buffer is empty, enq_valid=1, deq_ready=1 and no flush, the enq_* data passes combinationally to deq_* with deq_valid=1. Nothing is written, the pointers are unchanged, and the shadow rules apply to the bypassed instruction. This gives zero-cycle latency.
- Undefined: minimum latency is one cycle as described above.

Decomposition:
- rv32i_types package holds:
  - rv32i_word.
  - Opcode constants op_br=7'b1100011 and op_jalr=7'b1100111; reuse them if already present, otherwise add them there.
  - A packed struct fetch_entry_t {rv32i_word instr; rv32i_word pc;}.
- Sub-module shadow_tracker holds:
  - The saturating up/down counter with inputs inc, dec, clr and max-detect.
  - Outputs under_shadow and at_max.
  - It is instantiated once in fetch_buffer.

Test Plan:
1. Reset, then enqueue 8 non-branch instructions (instr=0x00000013, pc=0x0..0x1C) with deq_ready=0 -> count=8, enq_ready=0. A 9th enqueue is ignored. Draining yields the pcs 0x0..0x1C in order, and deq_valid falls after the last.
2. Continuous enqueue and dequeue for 20 cycles across wrap -> count stays 1, pcs are in order with no loss or duplication, and the wrap bit toggles.
3. Dequeue a beq (0x00000063), then an addi -> addi shows under_shadow=1. After br_resolve=1, the next head shows under_shadow=0.
4. Dequeue 7 branches without resolve (SHADOW_W=3) -> 8th branch at the head gives deq_valid=0. A single br_resolve gives deq_valid=1 the next cycle. Dequeue plus resolve in the same cycle leaves the count unchanged.
5. Buffer holds 5 entries, shadow_cnt=2, flush asserted together with enq_valid -> next cycle count=0, deq_valid=0, under_shadow=0, and the enqueued entry is absent.
6. With FETCH_BUF_BYPASS_EN and the buffer empty: enq_valid=1, deq_ready=1, pc=0x40 -> same cycle deq_valid=1, deq_pc=0x40, and count stays 0.
